// File: rtl/solver_thread_scheduler.sv
// Round-robin time-slicing of one WalkSAT datapath across NUM_THREADS solver contexts.
// Tracks per-thread flip budgets and ends the run on SAT or when every thread is exhausted.
module solver_thread_scheduler #(
  parameter int unsigned NUM_THREADS = 4,
  parameter logic [31:0] MAX_FLIPS   = 32'h00FF_FFFF,
  parameter int unsigned SLICE_FLIPS = 16,
  parameter int unsigned COUNT_WIDTH = 11
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          load_end_i,
  input  logic                          cpu_start_i,
  output logic [$clog2(NUM_THREADS)-1:0] load_thread_o,
  output logic                          load_ready_o,
  output logic                          flip_req_o,
  input  logic                          flip_ack_i,
  input  logic [COUNT_WIDTH-1:0]        unsat_buffer_count_i,
  output logic [$clog2(NUM_THREADS)-1:0] thread_sel_o,
  output logic                          ctx_switch_o,
  output logic                          cpu_done_o,
  output logic                          sat_o,
  output logic [$clog2(NUM_THREADS)-1:0] sat_thread_o
);

  localparam int unsigned TW = $clog2(NUM_THREADS);
  localparam int unsigned SW = $clog2(SLICE_FLIPS + 1);

  typedef enum logic [2:0] {
    LOAD   = 3'd0,
    READY  = 3'd1,
    ISSUE  = 3'd2,
    EVAL   = 3'd3,
    SWITCH = 3'd4,
    DONE   = 3'd5
  } state_e;

  state_e                 state_q, state_d;
  logic [TW-1:0]          load_thread_q, load_thread_d;
  logic [TW-1:0]          sel_q, sel_d;
  logic [SW-1:0]          slice_q, slice_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [NUM_THREADS-1:0] exh_q, exh_d;
  logic                   sat_q, sat_d;
  logic [TW-1:0]          sat_thread_q, sat_thread_d;
  logic [31:0]            flips_q [NUM_THREADS];
  logic                   flip_inc;
  logic [TW-1:0]          next_sel;

  // First non-exhausted thread after sel, wrapping; falls back to sel itself.
  always_comb begin
    logic          found;
    logic [TW-1:0] cand;
    next_sel = sel_q;
    found    = 1'b0;
    cand     = '0;
    for (int unsigned i = 1; i < NUM_THREADS; i++) begin
      cand = TW'(32'(sel_q) + i);
      if (!found && !exh_q[cand]) begin
        next_sel = cand;
        found    = 1'b1;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    load_thread_d = load_thread_q;
    sel_d         = sel_q;
    slice_d       = slice_q;
    count_d       = count_q;
    exh_d         = exh_q;
    sat_d         = sat_q;
    sat_thread_d  = sat_thread_q;
    flip_inc      = 1'b0;
    case (state_q)
      LOAD: begin
        if (load_end_i) begin
          if (load_thread_q == TW'(NUM_THREADS - 1)) state_d = READY;
          else load_thread_d = load_thread_q + TW'(1);
        end
      end
      READY: begin
        if (cpu_start_i) begin
          sel_d   = '0;
          slice_d = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (flip_ack_i) begin
          count_d = unsat_buffer_count_i;
          state_d = EVAL;
        end
      end
      EVAL: begin
        flip_inc = 1'b1;
        slice_d  = slice_q + SW'(1);
        // SAT wins over exhaustion on the same flip.
        if (count_q == '0) begin
          sat_d        = 1'b1;
          sat_thread_d = sel_q;
          state_d      = DONE;
        end else if (flips_q[sel_q] + 32'd1 == MAX_FLIPS) begin
          exh_d[sel_q] = 1'b1;
          state_d      = (&exh_d) ? DONE : SWITCH;
        end else if (32'(slice_q) + 32'd1 == SLICE_FLIPS) begin
          state_d = SWITCH;
        end else begin
          state_d = ISSUE;
        end
      end
      SWITCH: begin
        slice_d = '0;
        sel_d   = next_sel;
        state_d = ISSUE;
      end
      DONE: begin
        state_d = DONE;
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= LOAD;
      load_thread_q <= '0;
      sel_q         <= '0;
      slice_q       <= '0;
      count_q       <= '0;
      exh_q         <= '0;
      sat_q         <= 1'b0;
      sat_thread_q  <= '0;
    end else begin
      state_q       <= state_d;
      load_thread_q <= load_thread_d;
      sel_q         <= sel_d;
      slice_q       <= slice_d;
      count_q       <= count_d;
      exh_q         <= exh_d;
      sat_q         <= sat_d;
      sat_thread_q  <= sat_thread_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned t = 0; t < NUM_THREADS; t++) flips_q[t] <= '0;
    end else begin
      for (int unsigned t = 0; t < NUM_THREADS; t++) begin
        if (flip_inc && sel_q == TW'(t)) flips_q[t] <= flips_q[t] + 32'd1;
      end
    end
  end

  assign load_thread_o = load_thread_q;
  assign load_ready_o  = (state_q == READY);
  assign flip_req_o    = (state_q == ISSUE);
  assign thread_sel_o  = sel_q;
  assign ctx_switch_o  = (state_q == SWITCH);
  assign cpu_done_o    = (state_q == DONE);
  assign sat_o         = sat_q;
  assign sat_thread_o  = sat_thread_q;

endmodule

// File: tb/tb_solver_thread_scheduler.sv
// Directed bench for solver_thread_scheduler: three instances with different budgets/slices.
module tb_solver_thread_scheduler;

  logic             clk;
  logic [2:0]       rst;
  logic [2:0]       load_end;
  logic [2:0]       cpu_start;
  logic [2:0]       flip_ack;
  logic [2:0][10:0] cnt;
  logic [2:0][1:0]  load_thread;
  logic [2:0]       load_ready;
  logic [2:0]       flip_req;
  logic [2:0][1:0]  thread_sel;
  logic [2:0]       ctx_switch;
  logic [2:0]       cpu_done;
  logic [2:0]       sat;
  logic [2:0][1:0]  sat_thread;

  int checks = 0;
  int errors = 0;

  // dut0: large budget, slice 4; dut1: budget 3, slice 2; dut2: budget 1, slice 2
  solver_thread_scheduler #(.NUM_THREADS(4), .MAX_FLIPS(32'd1000), .SLICE_FLIPS(4), .COUNT_WIDTH(11)) u_dut0 (
    .clk_i(clk), .rst_i(rst[0]), .load_end_i(load_end[0]), .cpu_start_i(cpu_start[0]),
    .load_thread_o(load_thread[0]), .load_ready_o(load_ready[0]), .flip_req_o(flip_req[0]),
    .flip_ack_i(flip_ack[0]), .unsat_buffer_count_i(cnt[0]), .thread_sel_o(thread_sel[0]),
    .ctx_switch_o(ctx_switch[0]), .cpu_done_o(cpu_done[0]), .sat_o(sat[0]), .sat_thread_o(sat_thread[0]));

  solver_thread_scheduler #(.NUM_THREADS(4), .MAX_FLIPS(32'd3), .SLICE_FLIPS(2), .COUNT_WIDTH(11)) u_dut1 (
    .clk_i(clk), .rst_i(rst[1]), .load_end_i(load_end[1]), .cpu_start_i(cpu_start[1]),
    .load_thread_o(load_thread[1]), .load_ready_o(load_ready[1]), .flip_req_o(flip_req[1]),
    .flip_ack_i(flip_ack[1]), .unsat_buffer_count_i(cnt[1]), .thread_sel_o(thread_sel[1]),
    .ctx_switch_o(ctx_switch[1]), .cpu_done_o(cpu_done[1]), .sat_o(sat[1]), .sat_thread_o(sat_thread[1]));

  solver_thread_scheduler #(.NUM_THREADS(4), .MAX_FLIPS(32'd1), .SLICE_FLIPS(2), .COUNT_WIDTH(11)) u_dut2 (
    .clk_i(clk), .rst_i(rst[2]), .load_end_i(load_end[2]), .cpu_start_i(cpu_start[2]),
    .load_thread_o(load_thread[2]), .load_ready_o(load_ready[2]), .flip_req_o(flip_req[2]),
    .flip_ack_i(flip_ack[2]), .unsat_buffer_count_i(cnt[2]), .thread_sel_o(thread_sel[2]),
    .ctx_switch_o(ctx_switch[2]), .cpu_done_o(cpu_done[2]), .sat_o(sat[2]), .sat_thread_o(sat_thread[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse_load(input int d);
    load_end[d] = 1'b1;
    tick();
    load_end[d] = 1'b0;
  endtask

  task automatic pulse_start(input int d);
    cpu_start[d] = 1'b1;
    tick();
    cpu_start[d] = 1'b0;
  endtask

  task automatic load_all(input int d);
    for (int i = 0; i < 4; i++) pulse_load(d);
  endtask

  // Waits (bounded) for a request, acks it with count c; returns at the EVAL cycle.
  task automatic do_ack(input int d, input logic [10:0] c, output logic [1:0] sel_seen);
    int n;
    n = 0;
    while (!flip_req[d] && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (flip_req[d] !== 1'b1) begin
      errors++;
      $display("FAIL ack_wait dut%0d: flip_req=%b required 1", d, flip_req[d]);
    end
    sel_seen    = thread_sel[d];
    flip_ack[d] = 1'b1;
    cnt[d]      = c;
    tick();
    flip_ack[d] = 1'b0;
  endtask

  task automatic test_reset();
    logic [9:0] obs;
    tick();
    for (int d = 0; d < 3; d++) begin
      obs = {load_thread[d], load_ready[d], flip_req[d], thread_sel[d], ctx_switch[d], cpu_done[d], sat[d]};
      checks++;
      if (obs !== 10'd0 || sat_thread[d] !== 2'd0) begin
        errors++;
        $display("FAIL reset dut%0d: outputs=%b/%b required 0", d, obs, sat_thread[d]);
      end
    end
    rst = 3'b000;
    tick();
  endtask

  task automatic test_load();
    logic [1:0] exp_lt;
    checks++;
    if (load_thread[0] !== 2'd0) begin
      errors++;
      $display("FAIL load_init: load_thread=%0d required 0", load_thread[0]);
    end
    for (int i = 0; i < 4; i++) begin
      pulse_load(0);
      exp_lt = (i == 3) ? 2'd3 : 2'(i + 1);
      checks++;
      if (load_thread[0] !== exp_lt || load_ready[0] !== (i == 3)) begin
        errors++;
        $display("FAIL load_step%0d: load_thread=%0d ready=%b required %0d/%b",
                 i, load_thread[0], load_ready[0], exp_lt, (i == 3));
      end
      if (i == 0) pulse_start(0);
      else tick();
      tick();
      checks++;
      if (flip_req[0] !== 1'b0) begin
        errors++;
        $display("FAIL load_stray_start%0d: flip_req=%b required 0", i, flip_req[0]);
      end
    end
  endtask

  task automatic test_ack_in_ready();
    flip_ack[0] = 1'b1;
    cnt[0]      = 11'd0;
    tick();
    flip_ack[0] = 1'b0;
    tick();
    checks++;
    if (load_ready[0] !== 1'b1 || flip_req[0] !== 1'b0 || cpu_done[0] !== 1'b0) begin
      errors++;
      $display("FAIL ready_ack: ready=%b req=%b done=%b required 1/0/0",
               load_ready[0], flip_req[0], cpu_done[0]);
    end
  endtask

  task automatic test_immediate_sat();
    logic [1:0] s;
    pulse_start(0);
    checks++;
    if (flip_req[0] !== 1'b1 || thread_sel[0] !== 2'd0) begin
      errors++;
      $display("FAIL start_req: req=%b sel=%0d required 1/0", flip_req[0], thread_sel[0]);
    end
    do_ack(0, 11'd0, s);
    checks++;
    if (flip_req[0] !== 1'b0 || cpu_done[0] !== 1'b0) begin
      errors++;
      $display("FAIL sat_eval: req=%b done=%b required 0/0", flip_req[0], cpu_done[0]);
    end
    tick();
    checks++;
    if ({cpu_done[0], sat[0], sat_thread[0]} !== 4'b1100) begin
      errors++;
      $display("FAIL sat_done: done/sat/thr=%b required 1100", {cpu_done[0], sat[0], sat_thread[0]});
    end
    flip_ack[0] = 1'b1; cpu_start[0] = 1'b1; load_end[0] = 1'b1; cnt[0] = 11'd9;
    tick();
    flip_ack[0] = 1'b0; cpu_start[0] = 1'b0; load_end[0] = 1'b0;
    tick();
    checks++;
    if ({cpu_done[0], sat[0], sat_thread[0], flip_req[0]} !== 5'b11000) begin
      errors++;
      $display("FAIL done_hold: done/sat/thr/req=%b required 11000",
               {cpu_done[0], sat[0], sat_thread[0], flip_req[0]});
    end
  endtask

  task automatic test_rotation();
    logic [1:0] s;
    logic [1:0] exp_sel;
    rst[0] = 1'b1;
    tick();
    rst[0] = 1'b0;
    load_all(0);
    pulse_start(0);
    for (int k = 0; k < 16; k++) begin
      do_ack(0, 11'd5, s);
      exp_sel = 2'((k / 4) % 4);
      checks++;
      if (s !== exp_sel) begin
        errors++;
        $display("FAIL rot_sel%0d: sel=%0d required %0d", k, s, exp_sel);
      end
      tick();
      checks++;
      if (ctx_switch[0] !== ((k % 4) == 3) || cpu_done[0] !== 1'b0) begin
        errors++;
        $display("FAIL rot_switch%0d: ctx_switch=%b done=%b required %b/0",
                 k, ctx_switch[0], cpu_done[0], ((k % 4) == 3));
      end
      if ((k % 4) == 3) begin
        // stray ack while switching must be ignored
        flip_ack[0] = 1'b1;
        tick();
        flip_ack[0] = 1'b0;
      end
    end
    checks++;
    if (flip_req[0] !== 1'b1 || thread_sel[0] !== 2'd0) begin
      errors++;
      $display("FAIL rot_wrap: req=%b sel=%0d required 1/0", flip_req[0], thread_sel[0]);
    end
  endtask

  task automatic test_reset_mid_issue();
    logic [1:0] s;
    for (int k = 0; k < 4; k++) begin
      do_ack(0, 11'd5, s);
      tick();
    end
    tick();
    checks++;
    if (flip_req[0] !== 1'b1 || thread_sel[0] !== 2'd1) begin
      errors++;
      $display("FAIL pre_rst: req=%b sel=%0d required 1/1", flip_req[0], thread_sel[0]);
    end
    rst[0] = 1'b1;
    #1;
    checks++;
    if ({load_thread[0], load_ready[0], flip_req[0], thread_sel[0], ctx_switch[0],
         cpu_done[0], sat[0], sat_thread[0]} !== 12'd0) begin
      errors++;
      $display("FAIL async_rst: outputs=%b required 0",
               {load_thread[0], load_ready[0], flip_req[0], thread_sel[0], ctx_switch[0],
                cpu_done[0], sat[0], sat_thread[0]});
    end
    tick();
    rst[0] = 1'b0;
    load_all(0);
    checks++;
    if (load_ready[0] !== 1'b1) begin
      errors++;
      $display("FAIL reload: ready=%b required 1", load_ready[0]);
    end
    pulse_start(0);
    for (int k = 0; k < 4; k++) begin
      do_ack(0, 11'd5, s);
      tick();
    end
    do_ack(0, 11'd0, s);
    checks++;
    if (s !== 2'd1) begin
      errors++;
      $display("FAIL rerun_sel: sel=%0d required 1", s);
    end
    tick();
    checks++;
    if ({cpu_done[0], sat[0], sat_thread[0]} !== 4'b1101) begin
      errors++;
      $display("FAIL rerun_sat: done/sat/thr=%b required 1101", {cpu_done[0], sat[0], sat_thread[0]});
    end
  endtask

  task automatic test_exhaustion();
    logic [1:0] s;
    logic [1:0] exp_sel;
    logic       exp_sw;
    load_all(1);
    pulse_start(1);
    for (int k = 0; k < 12; k++) begin
      do_ack(1, 11'd7, s);
      exp_sel = (k < 8) ? 2'(k / 2) : 2'(k - 8);
      checks++;
      if (s !== exp_sel) begin
        errors++;
        $display("FAIL exh_sel%0d: sel=%0d required %0d", k, s, exp_sel);
      end
      tick();
      if (k < 11) begin
        exp_sw = (k < 8) ? ((k % 2) == 1) : 1'b1;
        checks++;
        if (ctx_switch[1] !== exp_sw || cpu_done[1] !== 1'b0) begin
          errors++;
          $display("FAIL exh_switch%0d: ctx_switch=%b done=%b required %b/0",
                   k, ctx_switch[1], cpu_done[1], exp_sw);
        end
      end else begin
        checks++;
        if (cpu_done[1] !== 1'b1 || sat[1] !== 1'b0 || ctx_switch[1] !== 1'b0) begin
          errors++;
          $display("FAIL exh_done: done=%b sat=%b sw=%b required 1/0/0",
                   cpu_done[1], sat[1], ctx_switch[1]);
        end
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [1:0] s;
    load_all(2);
    pulse_start(2);
    do_ack(2, 11'd0, s);
    tick();
    checks++;
    if ({cpu_done[2], sat[2], sat_thread[2], ctx_switch[2]} !== 5'b11000) begin
      errors++;
      $display("FAIL simul_sat: done/sat/thr/sw=%b required 11000",
               {cpu_done[2], sat[2], sat_thread[2], ctx_switch[2]});
    end
  endtask

  initial begin
    rst       = 3'b111;
    load_end  = '0;
    cpu_start = '0;
    flip_ack  = '0;
    cnt       = '0;
    test_reset();
    test_load();
    test_ack_in_ready();
    test_immediate_sat();
    test_rotation();
    test_reset_mid_issue();
    test_exhaustion();
    test_simultaneous();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
